// File: rtl/snow64_instr_mem_responder_pkg.sv
// rtl/snow64_instr_mem_responder_pkg.sv - shared types and widths for the instruction-memory responder
//
// Purpose: FSM state encoding and the line/word geometry used by the
//          responder top and its backing store.
// Ports:   none (package).
package PkgSnow64InstrMemResponder;

  // Geometry of an instruction-cache line and of one instruction.
  localparam int unsigned ICACHE_LINE_WIDTH = 256;
  localparam int unsigned INSTR_WIDTH       = 32;
  localparam int unsigned INSTRS_PER_LINE   = ICACHE_LINE_WIDTH / INSTR_WIDTH;

  // Backing-store word and the number of beats needed to assemble a line.
  localparam int unsigned WORD_WIDTH     = 64;
  localparam int unsigned BEATS_PER_LINE = ICACHE_LINE_WIDTH / WORD_WIDTH;
  localparam int unsigned BEAT_W         = $clog2(BEATS_PER_LINE);

  localparam int unsigned ADDR_WIDTH = 64;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StFill = 2'd2
  } state_e;

endpackage

// File: rtl/snow64_instr_mem_backing_store.sv
// rtl/snow64_instr_mem_backing_store.sv - word-wide backing array with one write port and a combinational read
//
// Purpose: DEPTH_WORDS x 64-bit program storage, kept as its own module so
//          it can be swapped for a real memory macro later.
// Ports:
//   clk        clock
//   wr_en_i    write enable (already qualified by the caller)
//   wr_idx_i   word index to write
//   wr_data_i  write data
//   rd_idx_i   word index to read
//   rd_data_o  read data, combinational from rd_idx_i
module snow64_instr_mem_backing_store
  import PkgSnow64InstrMemResponder::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           wr_en_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx_i,
  input  logic [WORD_WIDTH-1:0]          wr_data_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx_i,
  output logic [WORD_WIDTH-1:0]          rd_data_o
);

  // Contents survive reset on purpose: program images are preloaded once.
  logic [WORD_WIDTH-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/snow64_instr_mem_responder.sv
// rtl/snow64_instr_mem_responder.sv - instruction-cache line-fill responder over a 64-bit backing store
//
// Purpose: captures a one-cycle line-fill request, waits LATENCY cycles,
//          gathers four 64-bit words into a 256-bit line and returns it with
//          a one-cycle valid pulse. A word-write port preloads the store.
// Optional feature macro: SNOW64_INSTR_MEM_RESPONDER_ERR_EN
//   defined   - out-of-range requests return a zero line with out_err,
//               out-of-range writes are dropped, out_err port exists
//   undefined - addresses wrap modulo DEPTH_WORDS, no out_err port
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   in_req        line-fill request pulse
//   in_addr       request byte address, bits [4:0] ignored
//   in_wr_en      backing-store write enable (honoured only when idle)
//   in_wr_addr    write byte address, bits [2:0] ignored
//   in_wr_data    write data
//   out_valid     line valid pulse
//   out_data      returned line, instruction k at [32k+31:32k]
//   out_busy      high whenever the FSM is not idle
//   out_err       out-of-range flag (optional feature only)
module snow64_instr_mem_responder
  import PkgSnow64InstrMemResponder::*;
#(
  parameter int unsigned LATENCY     = 3,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_req,
  input  logic [ADDR_WIDTH-1:0]        in_addr,
  input  logic                         in_wr_en,
  input  logic [ADDR_WIDTH-1:0]        in_wr_addr,
  input  logic [WORD_WIDTH-1:0]        in_wr_data,
  output logic                         out_valid,
  output logic [ICACHE_LINE_WIDTH-1:0] out_data,
  output logic                         out_busy
`ifdef SNOW64_INSTR_MEM_RESPONDER_ERR_EN
  ,
  output logic                         out_err
`endif
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned LINE_W = IDX_W - BEAT_W;
  localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e                       state_q;
  logic [CNT_W-1:0]             cnt_q;
  logic [BEAT_W-1:0]            beat_q;
  logic [LINE_W-1:0]            line_q;
  logic [ICACHE_LINE_WIDTH-1:0] buf_q;
  logic [ICACHE_LINE_WIDTH-1:0] line_d;
  logic [ICACHE_LINE_WIDTH-1:0] data_q;
  logic                         valid_q;
  logic                         busy_q;

  logic                         store_wr_en;
  logic [WORD_WIDTH-1:0]        rd_data;
  logic [WORD_WIDTH-1:0]        fill_word;
  logic                         unused_bits;

  // Only the index bits of each address reach the store; the rest either
  // wrap away or feed the optional range check.
  assign unused_bits = ^{in_addr[4:0], in_wr_addr[2:0],
                         in_addr[ADDR_WIDTH-1:IDX_W+3], in_wr_addr[ADDR_WIDTH-1:IDX_W+3]};

`ifdef SNOW64_INSTR_MEM_RESPONDER_ERR_EN
  logic oor_q;
  logic err_q;
  logic req_oor;
  logic wr_oor;

  // Word address >= DEPTH_WORDS exactly when any bit above the index is set.
  assign req_oor     = |in_addr[ADDR_WIDTH-1:IDX_W+3];
  assign wr_oor      = |in_wr_addr[ADDR_WIDTH-1:IDX_W+3];
  assign store_wr_en = in_wr_en && (state_q == StIdle) && !wr_oor;
  assign fill_word   = oor_q ? '0 : rd_data;
  assign out_err     = err_q;
`else
  assign store_wr_en = in_wr_en && (state_q == StIdle);
  assign fill_word   = rd_data;
`endif

  snow64_instr_mem_backing_store #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_store (
    .clk       (clk),
    .wr_en_i   (store_wr_en),
    .wr_idx_i  (in_wr_addr[IDX_W+2:3]),
    .wr_data_i (in_wr_data),
    .rd_idx_i  ({line_q, beat_q}),
    .rd_data_o (rd_data)
  );

  // Line register with the current beat's word dropped into its slot; on the
  // last beat this is the complete line handed to out_data.
  always_comb begin
    line_d = buf_q;
    line_d[int'(beat_q) * WORD_WIDTH +: WORD_WIDTH] = fill_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      beat_q  <= '0;
      line_q  <= '0;
      buf_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SNOW64_INSTR_MEM_RESPONDER_ERR_EN
      oor_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
`ifdef SNOW64_INSTR_MEM_RESPONDER_ERR_EN
      err_q   <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (in_req) begin
            line_q <= in_addr[IDX_W+2:5];
            beat_q <= '0;
            busy_q <= 1'b1;
`ifdef SNOW64_INSTR_MEM_RESPONDER_ERR_EN
            oor_q  <= req_oor;
`endif
            if (LATENCY > 0) begin
              state_q <= StWait;
              cnt_q   <= CNT_W'(LATENCY - 1);
            end else begin
              state_q <= StFill;
            end
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_q <= StFill;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StFill: begin
          buf_q  <= line_d;
          beat_q <= beat_q + 1'b1;
          if (beat_q == BEAT_W'(BEATS_PER_LINE - 1)) begin
            data_q  <= line_d;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
`ifdef SNOW64_INSTR_MEM_RESPONDER_ERR_EN
            err_q   <= oor_q;
`endif
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_busy  = busy_q;

endmodule

// File: tb/tb_snow64_instr_mem_responder.sv
// tb/tb_snow64_instr_mem_responder.sv - directed self-checking bench for the instruction-memory responder
//
// Purpose: drives two responders (LATENCY=3 and LATENCY=0) with directed
//          fills, resets, busy-time requests/writes and range cases.
// Optional feature macro: SNOW64_INSTR_MEM_RESPONDER_ERR_EN
module tb_snow64_instr_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_req0, in_req1;
  logic [63:0]  in_addr0, in_addr1;
  logic         in_wr_en0, in_wr_en1;
  logic [63:0]  in_wr_addr, in_wr_data;
  logic         o0_valid, o1_valid, o0_busy, o1_busy;
  logic [255:0] o0_data, o1_data;
`ifdef SNOW64_INSTR_MEM_RESPONDER_ERR_EN
  logic         o0_err, o1_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  snow64_instr_mem_responder #(.LATENCY(3), .DEPTH_WORDS(1024)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .in_req     (in_req0),
    .in_addr    (in_addr0),
    .in_wr_en   (in_wr_en0),
    .in_wr_addr (in_wr_addr),
    .in_wr_data (in_wr_data),
    .out_valid  (o0_valid),
    .out_data   (o0_data),
    .out_busy   (o0_busy)
`ifdef SNOW64_INSTR_MEM_RESPONDER_ERR_EN
    ,
    .out_err    (o0_err)
`endif
  );

  snow64_instr_mem_responder #(.LATENCY(0), .DEPTH_WORDS(1024)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .in_req     (in_req1),
    .in_addr    (in_addr1),
    .in_wr_en   (in_wr_en1),
    .in_wr_addr (in_wr_addr),
    .in_wr_data (in_wr_data),
    .out_valid  (o1_valid),
    .out_data   (o1_data),
    .out_busy   (o1_busy)
`ifdef SNOW64_INSTR_MEM_RESPONDER_ERR_EN
    ,
    .out_err    (o1_err)
`endif
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Line whose instruction k holds the value base+k.
  function automatic logic [255:0] mk_line(input int unsigned base);
    logic [255:0] l;
    l = '0;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = 32'(base + k);
    return l;
  endfunction

  task automatic wr_both(input logic [63:0] a, input logic [63:0] d);
    in_wr_en0 = 1'b1; in_wr_en1 = 1'b1; in_wr_addr = a; in_wr_data = d;
    @(negedge clk);
    in_wr_en0 = 1'b0; in_wr_en1 = 1'b0;
  endtask

  // Entered at the negedge where the request was raised; returns at the
  // negedge just after the edge that should raise valid.
  task automatic wait_fill(input bit sel, input string tag, input int lat,
                           input logic [255:0] exp_line, input logic exp_err);
    @(negedge clk);
    in_req0 = 1'b0; in_req1 = 1'b0; in_wr_en0 = 1'b0; in_wr_en1 = 1'b0;
    chk({tag, " busy after capture"}, sel ? o1_busy : o0_busy, 256'd1);
    for (int n = 1; n < lat + 4; n++) begin
      @(negedge clk);
      chk({tag, " no early valid"}, sel ? o1_valid : o0_valid, 256'd0);
      chk({tag, " busy while filling"}, sel ? o1_busy : o0_busy, 256'd1);
    end
    @(negedge clk);
    chk({tag, " valid"}, sel ? o1_valid : o0_valid, 256'd1);
    chk({tag, " idle at valid"}, sel ? o1_busy : o0_busy, 256'd0);
    chk({tag, " line"}, sel ? o1_data : o0_data, exp_line);
`ifdef SNOW64_INSTR_MEM_RESPONDER_ERR_EN
    chk({tag, " err"}, sel ? o1_err : o0_err, {255'd0, exp_err});
`else
    if (exp_err) chk({tag, " err unsupported"}, 256'd1, 256'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] exp_l;
    rst = 1'b1; in_req0 = 1'b0; in_req1 = 1'b0; in_addr0 = '0; in_addr1 = '0;
    in_wr_en0 = 1'b0; in_wr_en1 = 1'b0; in_wr_addr = '0; in_wr_data = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset valid", o0_valid, 256'd0);
    chk("reset busy", o0_busy, 256'd0);
    chk("reset data", o0_data, 256'd0);
    chk("reset busy lat0", o1_busy, 256'd0);
    rst = 1'b0;

    // Words 0..7: instruction pairs {2i+1, 2i}.
    for (int i = 0; i < 8; i++) wr_both(64'(i * 8), {32'(2 * i + 1), 32'(2 * i)});

    // Basic fill of line 0.
    in_req0 = 1'b1; in_addr0 = 64'h0;
    wait_fill(1'b0, "t1", 3, mk_line(0), 1'b0);
    @(negedge clk);
    chk("t1 valid drops", o0_valid, 256'd0);
    chk("t1 data holds", o0_data, mk_line(0));

    // Offset bits ignored, then a request on the edge valid drops.
    in_req0 = 1'b1; in_addr0 = 64'h1C;
    wait_fill(1'b0, "t2", 3, mk_line(0), 1'b0);
    in_req0 = 1'b1; in_addr0 = 64'h20;
    wait_fill(1'b0, "b2b", 3, mk_line(8), 1'b0);
    @(negedge clk);
    chk("b2b valid drops", o0_valid, 256'd0);

    // Zero latency.
    in_req1 = 1'b1; in_addr1 = 64'h20;
    wait_fill(1'b1, "t3 lat0", 0, mk_line(8), 1'b0);
    @(negedge clk);
    chk("t3 valid drops", o1_valid, 256'd0);

    // Reset two edges after capture.
    in_req0 = 1'b1; in_addr0 = 64'h0;
    @(negedge clk);
    in_req0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4 busy after reset", o0_busy, 256'd0);
    chk("t4 valid after reset", o0_valid, 256'd0);
    chk("t4 data after reset", o0_data, 256'd0);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("t4 no valid after abort", o0_valid, 256'd0);
    end
    in_req0 = 1'b1; in_addr0 = 64'h0;
    wait_fill(1'b0, "t4 refill", 3, mk_line(0), 1'b0);

    // Request and write while busy are both ignored.
    in_req0 = 1'b1; in_addr0 = 64'h0;
    @(negedge clk);
    chk("t5 busy", o0_busy, 256'd1);
    in_req0 = 1'b1; in_addr0 = 64'h20;
    in_wr_en0 = 1'b1; in_wr_addr = 64'h0; in_wr_data = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    in_req0 = 1'b0; in_wr_en0 = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      chk("t5 no early valid", o0_valid, 256'd0);
      @(negedge clk);
    end
    chk("t5 valid", o0_valid, 256'd1);
    chk("t5 line", o0_data, mk_line(0));
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("t5 no second valid", o0_valid, 256'd0);
      chk("t5 no queued request", o0_busy, 256'd0);
    end
    in_req0 = 1'b1; in_addr0 = 64'h0;
    wait_fill(1'b0, "t5 memory unchanged", 3, mk_line(0), 1'b0);
    @(negedge clk);

    // Write and request on the same edge: fill sees the new word.
    exp_l = mk_line(8);
    exp_l[63:0] = 64'hDEAD_BEEF_CAFE_F00D;
    in_req0 = 1'b1; in_addr0 = 64'h20;
    in_wr_en0 = 1'b1; in_wr_addr = 64'h20; in_wr_data = 64'hDEAD_BEEF_CAFE_F00D;
    wait_fill(1'b0, "wr+req", 3, exp_l, 1'b0);
    @(negedge clk);

    // Word address 1024 is one past the store.
    in_req0 = 1'b1; in_addr0 = 64'h2000;
`ifdef SNOW64_INSTR_MEM_RESPONDER_ERR_EN
    wait_fill(1'b0, "t6 out of range", 3, 256'd0, 1'b1);
    @(negedge clk);
    chk("t6 err drops", o0_err, 256'd0);
`else
    wait_fill(1'b0, "t6 wrap", 3, mk_line(0), 1'b0);
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/snow64_instr_mem_responder.md
Name: snow64_instr_mem_responder

Overview:
- Memory-side responder for instruction-cache line fills.
- Accepts a one-cycle line-fill request (`req`, `addr`) from the instruction cache's memory-access port.
- Reads one 256-bit line (8 × 32-bit instructions) from an internal 64-bit-word backing store over 4 beats, after a programmable access latency.
- Returns the line with a one-cycle `valid` pulse. A word-write port lets the bench or boot logic preload program contents.

Parameters:
- LATENCY, 3, idle cycles between request capture and first fill beat; 0 is legal.
- DEPTH_WORDS, 1024, backing-store depth in 64-bit words; must be a power of two and at least 4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_req  in  1  line-fill request, single-cycle pulse
- in_addr  in  64  byte address of the request; bits [4:0] are ignored (line aligned)
- in_wr_en  in  1  backing-store word write enable
- in_wr_addr  in  64  byte address of the write; bits [2:0] are ignored
- in_wr_data  in  64  write data
- out_valid  out  1  line data valid, single-cycle pulse
- out_data  out  256  returned line; instruction k occupies bits [32k+31:32k]
- out_busy  out  1  high in any state other than StIdle
- out_err  out  1  out-of-range flag; present only with the optional feature

Behaviour:
- Reset (rst=1 at an edge):
  - state becomes StIdle; out_valid, out_busy and out_err become 0; out_data becomes 0.
  - beat and latency counters clear.
  - Backing-store contents are NOT cleared.
  - A reset arriving mid-fill aborts the fill; no valid pulse is produced.
- Word index:
  - line = in_addr[63:5]; word = {line, beat[1:0]}.
  - The array index is word mod DEPTH_WORDS (low bits).
  - beat 0 maps to out_data[63:0] (instructions 0 and 1); beat 3 maps to [255:192].
- StIdle:
  - On in_req=1, capture line base and clear the beat counter.
  - If LATENCY>0, go to StWait with count=LATENCY-1; otherwise go to StFill.
  - out_valid<=0 on every StIdle edge not otherwise specified.
- StWait: decrement the counter each edge; at 0, go to StFill.
- StFill:
  - Each edge writes the indexed word into the line register at slot beat, then increments beat.
  - On the beat=3 edge: out_data<=complete line (including the beat-3 word), out_valid<=1, state<=StIdle.
- Latency:
  - Capture edge E0; valid is visible after edge E(LATENCY+4).
  - Default: valid is seen 7 edges after capture.
  - out_valid drops on the next edge.
  - out_data holds its value until the next completed fill.
- Request while busy: ignored, no queueing. The initiator never issues one while waiting.
- Request on the same edge that out_valid drops (already in StIdle): captured normally.
- Writes:
  - Accepted only in StIdle; ignored while busy.
  - A write and a request on the same edge: the write commits and the request is captured. The fill observes the new data.
- out_busy is registered and equals (state != StIdle).

Optional Feature:
- Macro: SNOW64_INSTR_MEM_RESPONDER_ERR_EN.
- Defined:
  - A request whose word address (in_addr[63:3]) is ≥ DEPTH_WORDS returns an all-zero line.
  - out_err pulses high together with out_valid; timing is unchanged.
  - Out-of-range writes are dropped.
  - The out_err port exists.
- Undefined:
  - Addresses wrap modulo DEPTH_WORDS.
  - No out_err port.

Decomposition:
- Shared package PkgSnow64InstrMemResponder:
  - State enum {StIdle, StWait, StFill}.
  - Beats-per-line constant (256/64 = 4).
  - Line/word width constants derived from the existing icache line width and instruction width defines.
- Sub-module snow64_instr_mem_backing_store:
  - Single write port, combinational read, DEPTH_WORDS × 64.
  - Keeps the array separable for later replacement by a real memory.

Test Plan:
1. Preload words 0..3 = 0x0000000100000000, 0x0000000300000002, 0x0000000500000004, 0x0000000700000006.
   - Stimulus: in_req with in_addr=0x0.
   - Response: out_valid high for one cycle exactly 7 edges after capture; out_data instruction k == k for k=0..7; out_busy high for the 7 intervening cycles.
2. Same preload, in_addr=0x1C.
   - Response: identical line to test 1 (offset bits ignored).
3. Set LATENCY=0, request line at 0x20.
   - Response: valid 4 edges after capture.
4. Reset mid-fill.
   - Stimulus: assert rst 2 edges after capture.
   - Response: no out_valid; out_busy=0; out_data=0; a following request returns correct data.
5. Issue a second in_req while out_busy=1, and an in_wr_en while busy.
   - Response: both are ignored; a single valid pulse; memory is unchanged.
6. in_addr=0x2000 with DEPTH_WORDS=1024.
   - Macro defined: line all-zero and out_err=1 with valid.
   - Macro undefined: returns the line at 0x0.
